// File: rtl/location_sweeper.sv
// Frame sweeper: walks a write pointer over every cell of an X_MAX x Y_MAX grid,
// with a view pointer running VIEW_LEAD cells ahead to prefetch the next lookup.
// Optional build macro SWEEP_SERPENTINE_EN: odd rows scan X from X_MAX down to 0.
module location_sweeper #(
  parameter int unsigned X_BITS    = 8,
  parameter int unsigned Y_BITS    = 7,
  parameter int unsigned X_MAX     = 159,
  parameter int unsigned Y_MAX     = 119,
  parameter int unsigned VIEW_LEAD = 2
) (
  input  logic              newLocClock,
  input  logic              RESET_SIM,
  input  logic              game_tick,
  input  logic              pause,
  input  logic              step,
  input  logic              hold,
  output logic [X_BITS-1:0] write_x,
  output logic [Y_BITS-1:0] write_y,
  output logic [X_BITS-1:0] view_x,
  output logic [Y_BITS-1:0] view_y,
  output logic              write_flag,
  output logic              busy,
  output logic              frame_done,
  output logic              overrun,
  output logic [1:0]        state_o
);

`ifdef SWEEP_SERPENTINE_EN
  localparam bit Serp = 1'b1;
`else
  localparam bit Serp = 1'b0;
`endif

  localparam logic [X_BITS-1:0] XLast = X_BITS'(X_MAX);
  localparam logic [Y_BITS-1:0] YLast = Y_BITS'(Y_MAX);
  localparam logic [3:0]        Lead  = 4'(VIEW_LEAD);
  // Serpentine with an odd last row finishes the frame at column 0.
  localparam logic [X_BITS-1:0] XEnd  = (Serp && (Y_MAX % 2 == 1)) ? '0 : XLast;

  typedef enum logic [1:0] {StIdle = 2'd0, StPrime = 2'd1, StSweep = 2'd2, StDone = 2'd3} state_e;

  state_e            state_q, state_d;
  logic [X_BITS-1:0] wx_q, vx_q, wx_n, vx_n;
  logic [Y_BITS-1:0] wy_q, vy_q, wy_n, vy_n;
  logic [3:0]        prime_cnt_q;
  logic              frame_done_q, overrun_q;
  logic              start, at_last;

  // Successor of a cell in scan order, wrapping after the last cell to (0,0).
  function automatic logic [X_BITS+Y_BITS-1:0] next_cell(input logic [X_BITS-1:0] x,
                                                         input logic [Y_BITS-1:0] y);
    logic [X_BITS-1:0] nx;
    logic [Y_BITS-1:0] ny;
    logic              rev;
    logic              row_end;
    rev     = Serp & y[0];
    row_end = rev ? (x == '0) : (x == XLast);
    nx      = rev ? (x - X_BITS'(1)) : (x + X_BITS'(1));
    ny      = y;
    if (row_end) begin
      // A reversed row next starts where the forward row ended.
      nx = (Serp && !rev) ? XLast : '0;
      if (y == YLast) begin
        nx = '0;
        ny = '0;
      end else begin
        ny = y + Y_BITS'(1);
      end
    end
    return {nx, ny};
  endfunction

  assign {wx_n, wy_n} = next_cell(wx_q, wy_q);
  assign {vx_n, vy_n} = next_cell(vx_q, vy_q);

  assign start   = (game_tick & ~pause) | (step & pause);
  assign at_last = (wx_q == XEnd) && (wy_q == YLast);

  // State register.
  always_ff @(posedge newLocClock) begin
    if (RESET_SIM) state_q <= StIdle;
    else           state_q <= state_d;
  end

  // Next-state decode; hold freezes PRIME and SWEEP, DONE always returns to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = (VIEW_LEAD != 0) ? StPrime : StSweep;
      StPrime: if (!hold && (prime_cnt_q == Lead - 4'd1)) state_d = StSweep;
      StSweep: if (!hold && at_last) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from registered state and hold.
  always_comb begin
    busy       = (state_q != StIdle);
    write_flag = (state_q == StSweep) & ~hold;
    state_o    = state_q;
  end

  // Pointers, PRIME counter and registered status flags.
  always_ff @(posedge newLocClock) begin
    if (RESET_SIM) begin
      wx_q         <= '0;
      wy_q         <= '0;
      vx_q         <= '0;
      vy_q         <= '0;
      prime_cnt_q  <= '0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      frame_done_q <= (state_d == StDone);
      // Starts while busy are dropped but remembered until reset.
      overrun_q    <= overrun_q | (start & (state_q != StIdle));
      case (state_q)
        StPrime: begin
          if (!hold) begin
            vx_q        <= vx_n;
            vy_q        <= vy_n;
            prime_cnt_q <= prime_cnt_q + 4'd1;
          end
        end
        StSweep: begin
          if (!hold) begin
            wx_q <= wx_n;
            wy_q <= wy_n;
            vx_q <= vx_n;
            vy_q <= vy_n;
          end
        end
        StDone: begin
          wx_q        <= '0;
          wy_q        <= '0;
          vx_q        <= '0;
          vy_q        <= '0;
          prime_cnt_q <= '0;
        end
        default: prime_cnt_q <= '0;
      endcase
    end
  end

  assign write_x    = wx_q;
  assign write_y    = wy_q;
  assign view_x     = vx_q;
  assign view_y     = vy_q;
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_location_sweeper.sv
// Bench for location_sweeper on a 4x2 grid: dut1 with VIEW_LEAD=2, dut2 with VIEW_LEAD=0.
// Expected cell sequences are queued per frame; negedge monitors pop and compare on write_flag.
module tb_location_sweeper;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, gt, pause, step, hold;
  logic gt2, pause2, step2, hold2;

  logic [7:0] w1x, v1x, w2x, v2x;
  logic [6:0] w1y, v1y, w2y, v2y;
  logic       wf1, busy1, fd1, ovr1, wf2, busy2, fd2, ovr2;
  logic [1:0] st1, st2;

  location_sweeper #(.X_BITS(8), .Y_BITS(7), .X_MAX(3), .Y_MAX(1), .VIEW_LEAD(2)) dut1 (
    .newLocClock(clk), .RESET_SIM(rst), .game_tick(gt), .pause(pause), .step(step),
    .hold(hold), .write_x(w1x), .write_y(w1y), .view_x(v1x), .view_y(v1y),
    .write_flag(wf1), .busy(busy1), .frame_done(fd1), .overrun(ovr1), .state_o(st1)
  );

  location_sweeper #(.X_BITS(8), .Y_BITS(7), .X_MAX(3), .Y_MAX(1), .VIEW_LEAD(0)) dut2 (
    .newLocClock(clk), .RESET_SIM(rst), .game_tick(gt2), .pause(pause2), .step(step2),
    .hold(hold2), .write_x(w2x), .write_y(w2y), .view_x(v2x), .view_y(v2y),
    .write_flag(wf2), .busy(busy2), .frame_done(fd2), .overrun(ovr2), .state_o(st2)
  );

  int errors = 0;
  int checks = 0;
  int fd1_cnt = 0;
  int fd2_cnt = 0;
  int ox[8];
  int oy[8];
  logic [31:0] q1[$];
  logic [31:0] q2[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Queue one frame of {write_x, write_y, view_x, view_y} entries.
  task automatic push_frame(input bit sel, input int lead);
    logic [31:0] e;
    for (int i = 0; i < 8; i++) begin
      e = {8'(ox[i]), 8'(oy[i]), 8'(ox[(i + lead) % 8]), 8'(oy[(i + lead) % 8])};
      if (sel) q2.push_back(e);
      else     q1.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (fd1) fd1_cnt++;
    if (wf1) begin
      if (q1.size() == 0) check("sb1_unexpected_write", {w1x, 1'b0, w1y}, 32'hffff);
      else check("sb1_cell", {w1x, 1'b0, w1y, v1x, 1'b0, v1y}, q1.pop_front());
    end
  end

  always @(negedge clk) begin
    if (fd2) fd2_cnt++;
    if (wf2) begin
      if (q2.size() == 0) check("sb2_unexpected_write", {w2x, 1'b0, w2y}, 32'hffff);
      else check("sb2_cell", {w2x, 1'b0, w2y, v2x, 1'b0, v2y}, q2.pop_front());
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Issue a start and step until frame_done; cycles counts edges from the start edge.
  task automatic run_frame(input bit sel, input bit use_step, input bit do_hold,
                           input bit do_ovr, output int cycles, output int primes,
                           output int sweeps);
    int holdc;
    bit ovr_done;
    logic [1:0] st;
    holdc = 0;
    ovr_done = 1'b0;
    if (sel) gt2 = 1'b1;
    else if (use_step) step = 1'b1;
    else gt = 1'b1;
    cycles = 0;
    primes = 0;
    sweeps = 0;
    for (int k = 0; k < 100; k++) begin
      cycle();
      gt = 1'b0;
      gt2 = 1'b0;
      step = 1'b0;
      cycles++;
      st = sel ? st2 : st1;
      if (st == 2'd1) primes++;
      if (st == 2'd2) sweeps++;
      if ((sel ? fd2 : fd1) == 1'b1) break;
      if (k == 99) check("frame_timeout", 32'd0, 32'd1);
      if (do_hold && st == 2'd2 && w1x == 8'd1 && w1y == 7'd0 && holdc < 3) begin
        hold = 1'b1;
        holdc++;
        #1;
        check("hold_flag", {31'd0, wf1}, 32'd0);
      end else begin
        hold = 1'b0;
      end
      if (do_ovr && st == 2'd2 && !ovr_done) begin
        gt = 1'b1;
        ovr_done = 1'b1;
      end
    end
    hold = 1'b0;
  endtask

  initial begin
    int c, p, s, f0;
    bit found;
    bit ovr_sent;
`ifdef SWEEP_SERPENTINE_EN
    ox = '{0, 1, 2, 3, 3, 2, 1, 0};
`else
    ox = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif
    oy = '{0, 0, 0, 0, 1, 1, 1, 1};
    rst = 1'b1; gt = 1'b0; pause = 1'b0; step = 1'b0; hold = 1'b0;
    gt2 = 1'b0; pause2 = 1'b0; step2 = 1'b0; hold2 = 1'b0;
    repeat (2) cycle();
    rst = 1'b0;
    cycle();

    // Reset state
    check("rst_state", {30'd0, st1}, 32'd0);
    check("rst_write", {w1x, 1'b0, w1y}, 32'd0);
    check("rst_view", {v1x, 1'b0, v1y}, 32'd0);
    check("rst_flags", {28'd0, wf1, busy1, fd1, ovr1}, 32'd0);
    check("rst_state2", {30'd0, st2}, 32'd0);

    // Normal frame
    push_frame(1'b0, 2);
    f0 = fd1_cnt;
    run_frame(1'b0, 1'b0, 1'b0, 1'b0, c, p, s);
    check("frame_len", c - 1, 32'd10);
    check("prime_cycles", p, 32'd2);
    check("sweep_cycles", s, 32'd8);
    cycle();
    check("done_pulse_one_cycle", {31'd0, fd1}, 32'd0);
    check("done_to_idle", {30'd0, st1}, 32'd0);
    check("done_count", fd1_cnt - f0, 32'd1);
    check("sb1_drained", q1.size(), 32'd0);
    check("no_overrun", {31'd0, ovr1}, 32'd0);

    // Hold for 3 cycles at write=(1,0)
    push_frame(1'b0, 2);
    run_frame(1'b0, 1'b0, 1'b1, 1'b0, c, p, s);
    check("hold_frame_len", c - 1, 32'd13);
    check("hold_sweep_cycles", s, 32'd11);
    cycle();
    check("hold_sb1_drained", q1.size(), 32'd0);

    // Overrun: tick during SWEEP
    push_frame(1'b0, 2);
    f0 = fd1_cnt;
    run_frame(1'b0, 1'b0, 1'b0, 1'b1, c, p, s);
    check("ovr_frame_len", c - 1, 32'd10);
    cycle();
    check("ovr_set", {31'd0, ovr1}, 32'd1);
    check("ovr_done_count", fd1_cnt - f0, 32'd1);
    check("ovr_idle", {30'd0, st1}, 32'd0);
    check("ovr_sb1_drained", q1.size(), 32'd0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("ovr_cleared", {31'd0, ovr1}, 32'd0);

    // Step while not paused is ignored
    step = 1'b1;
    cycle();
    step = 1'b0;
    check("step_unpaused_busy", {31'd0, busy1}, 32'd0);
    // Paused tick is ignored
    pause = 1'b1;
    gt = 1'b1;
    cycle();
    gt = 1'b0;
    check("paused_tick_busy", {31'd0, busy1}, 32'd0);
    cycle();
    check("paused_tick_idle", {30'd0, st1}, 32'd0);
    // Two step frames
    push_frame(1'b0, 2);
    run_frame(1'b0, 1'b1, 1'b0, 1'b0, c, p, s);
    check("step1_len", c - 1, 32'd10);
    cycle();
    push_frame(1'b0, 2);
    run_frame(1'b0, 1'b1, 1'b0, 1'b0, c, p, s);
    check("step2_len", c - 1, 32'd10);
    cycle();
    // Tick and step together while paused: exactly one frame
    push_frame(1'b0, 2);
    f0 = fd1_cnt;
    gt = 1'b1;
    run_frame(1'b0, 1'b1, 1'b0, 1'b0, c, p, s);
    check("tick_step_len", c - 1, 32'd10);
    repeat (3) cycle();
    check("tick_step_done_count", fd1_cnt - f0, 32'd1);
    check("tick_step_no_ovr", {31'd0, ovr1}, 32'd0);
    check("pause_sb1_drained", q1.size(), 32'd0);
    pause = 1'b0;

    // Reset mid-frame at write=(2,1)
    push_frame(1'b0, 2);
    found = 1'b0;
    ovr_sent = 1'b0;
    gt = 1'b1;
    for (int k = 0; k < 50; k++) begin
      cycle();
      gt = 1'b0;
      if (st1 == 2'd2 && w1x == 8'd2 && w1y == 7'd1) begin
        found = 1'b1;
        break;
      end
      if (st1 == 2'd2 && !ovr_sent) begin
        gt = 1'b1;
        ovr_sent = 1'b1;
      end
    end
    check("mid_reset_reached", {31'd0, found}, 32'd1);
    check("ovr_pre_reset", {31'd0, ovr1}, 32'd1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("mid_rst_state", {30'd0, st1}, 32'd0);
    check("mid_rst_write", {w1x, 1'b0, w1y}, 32'd0);
    check("mid_rst_view", {v1x, 1'b0, v1y}, 32'd0);
    check("mid_rst_flags", {29'd0, busy1, fd1, ovr1}, 32'd0);
    q1.delete();
    cycle();
    check("mid_rst_stays_idle", {30'd0, st1}, 32'd0);

    // VIEW_LEAD=0 instance: straight to SWEEP, view tracks write
    push_frame(1'b1, 0);
    f0 = fd2_cnt;
    run_frame(1'b1, 1'b0, 1'b0, 1'b0, c, p, s);
    check("lead0_len", c - 1, 32'd8);
    check("lead0_prime_cycles", p, 32'd0);
    check("lead0_sweep_cycles", s, 32'd8);
    cycle();
    check("lead0_idle", {30'd0, st2}, 32'd0);
    check("lead0_done_count", fd2_cnt - f0, 32'd1);
    check("sb2_drained", q2.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
